// File: rtl/traffic_phase_scheduler.sv
// ---------------------------------------------------------------------------
// traffic_phase_scheduler
//   Timed phase scheduler for a two-road intersection (road A, road B).
//   It shares the intersection between the roads using minimum and maximum
//   green times, a yellow time and an all-red clearance. The lamp codes are
//   driven directly. All timing is counted in ticks of a 1-per-second
//   timebase.
//
//   Optional feature: define PED_WALK_EN to enable the pedestrian walk phase.
//   Without it, ped_req is ignored, walk is held at 0 and PED is unreachable.
//   The port list is the same in both builds.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-low reset
//   tick     in   timebase enable, 1-cycle pulse; every state/timer update is gated by it
//   t[1:0]   in   t[0]=car waiting on A, t[1]=car waiting on B (sampled on tick cycles)
//   ped_req  in   pedestrian button, any-cycle pulse
//   sa[1:0]  out  road A lamp: 00=red 01=yellow 10=green
//   sb[1:0]  out  road B lamp, same encoding
//   phase    out  0=A_GRN 1=A_YEL 2=A_CLR 3=B_GRN 4=B_YEL 5=B_CLR 6=PED
//                 (this is the FSM state register, exposed for debug as well)
//   walk     out  pedestrian walk lamp
//
// Lamp encoding for sa/sb and phase are registered and change on the same
// edge as the state.
// ---------------------------------------------------------------------------
module traffic_phase_scheduler #(
  parameter int CW        = 8,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [1:0] t,
  input  logic       ped_req,
  output logic [1:0] sa,
  output logic [1:0] sb,
  output logic [2:0] phase,
  output logic       walk
);

  typedef enum logic [2:0] {
    A_GRN = 3'd0,
    A_YEL = 3'd1,
    A_CLR = 3'd2,
    B_GRN = 3'd3,
    B_YEL = 3'd4,
    B_CLR = 3'd5,
    PED   = 3'd6
  } state_t;

  // Durations widened to CW+1 bits so they compare directly with e.
  localparam logic [CW:0] G_MIN = (CW+1)'(GREEN_MIN);
  localparam logic [CW:0] G_MAX = (CW+1)'(GREEN_MAX);
  localparam logic [CW:0] Y_E   = (CW+1)'(YELLOW_T);
  localparam logic [CW:0] R_E   = (CW+1)'(ALLRED_T);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0]   e;          // elapsed ticks in this state, including the current one
  logic [1:0]    sa_q, sb_q;
  logic          ped_pend;

`ifdef PED_WALK_EN
  localparam logic [CW:0] W_E = (CW+1)'(WALK_T);
  logic ped_pend_q, ped_pend_d;
  logic dest_b_q, dest_b_d;  // green to enter after PED: 1 = road B, 0 = road A
  logic walk_q;
  assign ped_pend = ped_pend_q;
  assign walk     = walk_q;
`else
  logic unused_ped;
  assign unused_ped = ^{ped_req, WALK_T[0]};
  assign ped_pend   = 1'b0;
  assign walk       = 1'b0;
`endif

  // {sa, sb} for a given phase; anything that is not a green or yellow of a
  // legal phase shows all-red, so both roads can never be non-red together.
  function automatic logic [3:0] lamps(input state_t s);
    case (s)
      A_GRN:   lamps = 4'b10_00;
      A_YEL:   lamps = 4'b01_00;
      B_GRN:   lamps = 4'b00_10;
      B_YEL:   lamps = 4'b00_01;
      default: lamps = 4'b00_00;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    e       = {1'b0, cnt_q} + 1'b1;
`ifdef PED_WALK_EN
    ped_pend_d = ped_pend_q | ped_req;
    dest_b_d   = dest_b_q;
`endif
    if (tick) begin
      case (state_q)
        // Demand is sampled only here, at the green-exit tick.
        A_GRN: if ((t[1] & ((~t[0] & (e >= G_MIN)) | (e >= G_MAX))) |
                   (ped_pend & (e >= G_MIN)))
                 state_d = A_YEL;
        A_YEL: if (e == Y_E) state_d = A_CLR;
        A_CLR: if (e == R_E) begin
`ifdef PED_WALK_EN
                 if (ped_pend_q) begin
                   state_d  = PED;
                   dest_b_d = 1'b1;
                 end else
`endif
                   state_d = B_GRN;
               end
        B_GRN: if ((t[0] & ((~t[1] & (e >= G_MIN)) | (e >= G_MAX))) |
                   (ped_pend & (e >= G_MIN)))
                 state_d = B_YEL;
        B_YEL: if (e == Y_E) state_d = B_CLR;
        B_CLR: if (e == R_E) begin
`ifdef PED_WALK_EN
                 if (ped_pend_q) begin
                   state_d  = PED;
                   dest_b_d = 1'b0;
                 end else
`endif
                   state_d = A_GRN;
               end
`ifdef PED_WALK_EN
        PED:   if (e == W_E) state_d = dest_b_q ? B_GRN : A_GRN;
`endif
        // Unknown encodings (and PED when the walk feature is absent)
        // recover through a clearance interval.
        default: state_d = A_CLR;
      endcase

      // Timer restarts on every state entry and saturates at all-ones.
      if (state_d != state_q) cnt_d = '0;
      else if (!(&cnt_q))     cnt_d = cnt_q + 1'b1;

`ifdef PED_WALK_EN
      // Entering PED serves the pending request; a press on this very
      // cycle is kept for the next round.
      if (state_d == PED && state_q != PED) ped_pend_d = ped_req;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= A_GRN;
      cnt_q   <= '0;
      sa_q    <= 2'b10;
      sb_q    <= 2'b00;
`ifdef PED_WALK_EN
      ped_pend_q <= 1'b0;
      dest_b_q   <= 1'b0;
      walk_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      {sa_q, sb_q} <= lamps(state_d);
`ifdef PED_WALK_EN
      ped_pend_q <= ped_pend_d;
      dest_b_q   <= dest_b_d;
      walk_q     <= (state_d == PED);
`endif
    end
  end

  assign sa    = sa_q;
  assign sb    = sb_q;
  assign phase = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// ---------------------------------------------------------------------------
// tb_traffic_phase_scheduler
//   Directed test of traffic_phase_scheduler with default parameters.
//   Inputs change on the falling edge; outputs are observed on the falling
//   edge, half a cycle after the rising edge that updated them. Expected
//   phases are queued per tick from hand-computed sequences and popped after
//   each tick.
// ---------------------------------------------------------------------------
module tb_traffic_phase_scheduler;

  logic       clk     = 1'b0;
  logic       reset   = 1'b0;
  logic       tick    = 1'b0;
  logic [1:0] t       = 2'b00;
  logic       ped_req = 1'b0;
  logic [1:0] sa, sb;
  logic [2:0] phase;
  logic       walk;

  int n_cmp = 0;
  int n_err = 0;
  logic [2:0] exp_q[$];

  traffic_phase_scheduler dut (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .t       (t),
    .ped_req (ped_req),
    .sa      (sa),
    .sb      (sb),
    .phase   (phase),
    .walk    (walk)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Lamp table {sa, sb} for each phase.
  function automatic logic [3:0] exp_lamps(input logic [2:0] p);
    case (p)
      3'd0:    exp_lamps = 4'b1000;
      3'd1:    exp_lamps = 4'b0100;
      3'd3:    exp_lamps = 4'b0010;
      3'd4:    exp_lamps = 4'b0001;
      default: exp_lamps = 4'b0000;
    endcase
  endfunction

  task automatic check_phase(input string tag, input logic [2:0] p);
    check({tag, ".phase"}, 8'(phase), 8'(p));
    check({tag, ".lamps"}, 8'({sa, sb}), 8'(exp_lamps(p)));
    check({tag, ".walk"},  8'(walk), 8'(p == 3'd6));
  endtask

  // ---------------- drivers ----------------
  task automatic tick_pulse();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset held for two edges with tick high, to show reset wins over tick.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    tick  = 1'b1;
    idle(2);
    reset = 1'b1;
    tick  = 1'b0;
  endtask

  // Push expected phase p for n consecutive ticks.
  task automatic expect_run(input logic [2:0] p, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(p);
  endtask

  // Apply one tick per queued entry (with optional idle gaps) and compare.
  task automatic run_queue(input string tag, input int max_gap);
    int k = 0;
    while (exp_q.size() > 0) begin
      logic [2:0] p;
      tick_pulse();
      idle($urandom_range(0, max_gap));
      p = exp_q.pop_front();
      k++;
      check_phase($sformatf("%s.tick%0d", tag, k), p);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // 1: reset with tick asserted
    do_reset();
    check_phase("reset", 3'd0);

    // 2: no demand, A rests in green
    t = 2'b00;
    expect_run(3'd0, 20);
    run_queue("idle_green", 0);

    // 3: B demand only: yellow at tick 4, clear at 6, B green at 7
    do_reset();
    t = 2'b10;
    expect_run(3'd0, 3);
    expect_run(3'd1, 2);
    expect_run(3'd2, 1);
    expect_run(3'd3, 2);
    run_queue("b_demand", 0);

    // 4: both roads demand, full cycle at max green; random tick gaps
    do_reset();
    t = 2'b11;
    expect_run(3'd0, 9);
    expect_run(3'd1, 2);
    expect_run(3'd2, 1);
    expect_run(3'd3, 10);
    expect_run(3'd4, 2);
    expect_run(3'd5, 1);
    expect_run(3'd0, 2);
    run_queue("both_max", 3);

    // 5: reset during B_YEL aborts it, timer restarts
    do_reset();
    t = 2'b10;
    expect_run(3'd0, 3);
    expect_run(3'd1, 2);
    expect_run(3'd2, 1);
    expect_run(3'd3, 1);
    run_queue("to_b", 0);
    t = 2'b01;
    expect_run(3'd3, 3);
    expect_run(3'd4, 1);
    run_queue("to_b_yel", 0);
    @(negedge clk);
    reset = 1'b0;
    tick  = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    tick  = 1'b0;
    check_phase("mid_reset", 3'd0);
    t = 2'b10;
    expect_run(3'd0, 3);
    expect_run(3'd1, 1);
    run_queue("after_reset", 0);

    // 6: pedestrian request in A_GRN with no car demand
    do_reset();
    t = 2'b00;
    @(negedge clk) ped_req = 1'b1;
    @(negedge clk) ped_req = 1'b0;
`ifdef PED_WALK_EN
    expect_run(3'd0, 3);
    expect_run(3'd1, 2);
    expect_run(3'd2, 1);
    expect_run(3'd6, 3);
    expect_run(3'd3, 3);
`else
    expect_run(3'd0, 12);
`endif
    run_queue("ped", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
